// File: rtl/hash_pkg.sv
// Shared constants, state encoding and defaults for the CRC hash engine.
package hash_pkg;

    localparam int unsigned KEY_W_DEF   = 60;
    localparam int unsigned CHUNK_W_DEF = 20;
    localparam int unsigned HASH_W_DEF  = 15;
    localparam int unsigned TAG_W_DEF   = 4;

    // x^15 term implied; 1+x^2+x^3+x^4+x^7+x^8+x^9+x^11+x^13+x^15
    localparam logic [14:0] HASH_POLY_15 = 15'h2B9D;
    localparam logic [14:0] HASH_SEED_15 = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } hash_state_e;

endpackage

// File: rtl/crc_chunk_step.sv
// Combinational fold of CHUNK_W data bits (MSB first) into a Galois CRC register.
module crc_chunk_step #(
    parameter int unsigned        CHUNK_W = 20,
    parameter int unsigned        HASH_W  = 15,
    parameter logic [HASH_W-1:0]  POLY    = HASH_W'(15'h2B9D)
) (
    input  logic [HASH_W-1:0]  crc_in,
    input  logic [CHUNK_W-1:0] data,
    output logic [HASH_W-1:0]  crc_out
);

    // Unrolled bit-serial LFSR: shift left, xor the polynomial when feedback is set.
    always_comb begin
        logic [HASH_W-1:0] c;
        logic              fb;
        c  = crc_in;
        fb = 1'b0;
        for (int i = int'(CHUNK_W) - 1; i >= 0; i--) begin
            fb = c[HASH_W-1] ^ data[i];
            c  = {c[HASH_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/hash_crc_engine.sv
// Multi-cycle CRC hash engine: folds a key CHUNK_W bits per cycle, returns hash + tag.
module hash_crc_engine
    import hash_pkg::*;
#(
    parameter int unsigned       KEY_W   = KEY_W_DEF,
    parameter int unsigned       CHUNK_W = CHUNK_W_DEF,
    parameter int unsigned       HASH_W  = HASH_W_DEF,
    parameter logic [HASH_W-1:0] POLY    = HASH_W'(HASH_POLY_15),
    parameter logic [HASH_W-1:0] SEED    = HASH_W'(HASH_SEED_15),
    parameter int unsigned       TAG_W   = TAG_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic [KEY_W-1:0]  i_key,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_key_valid,
    output logic              o_key_ready,
    output logic [HASH_W-1:0] o_hash,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_hash_valid,
    input  logic              i_hash_ready
);

    localparam int unsigned NCHUNK = KEY_W / CHUNK_W;
    localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);

    hash_state_e        state_q, state_d;
    logic [HASH_W-1:0]  crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic [TAG_W-1:0]   otag_q, otag_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;

    logic [HASH_W-1:0]  step_crc_in;
    logic [CHUNK_W-1:0] step_data;
    logic [HASH_W-1:0]  step_crc_out;

    crc_chunk_step #(
        .CHUNK_W (CHUNK_W),
        .HASH_W  (HASH_W),
        .POLY    (POLY)
    ) u_step (
        .crc_in  (step_crc_in),
        .data    (step_data),
        .crc_out (step_crc_out)
    );

    // State, datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            crc_q   <= SEED;
            cnt_q   <= '0;
            key_q   <= '0;
            tag_q   <= '0;
            hash_q  <= SEED;
            otag_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            tag_q   <= tag_d;
            hash_q  <= hash_d;
            otag_q  <= otag_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and datapath: first chunk comes straight from i_key, the rest from the shift register.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        tag_d       = tag_q;
        hash_d      = hash_q;
        otag_d      = otag_q;
        step_crc_in = crc_q;
        step_data   = key_q[KEY_W-1 -: CHUNK_W];

        case (state_q)
            IDLE: begin
                step_crc_in = SEED;
                step_data   = i_key[KEY_W-1 -: CHUNK_W];
                if (i_key_valid) begin
                    crc_d = step_crc_out;
                    cnt_d = CNT_W'(1);
                    key_d = i_key << CHUNK_W;
                    tag_d = i_tag;
                    if (NCHUNK == 1) begin
                        state_d = DONE;
                        hash_d  = step_crc_out;
                        otag_d  = i_tag;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                crc_d = step_crc_out;
                cnt_d = cnt_q + CNT_W'(1);
                key_d = key_q << CHUNK_W;
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    state_d = DONE;
                    hash_d  = step_crc_out;
                    otag_d  = tag_q;
                end
            end
            DONE: begin
                if (i_hash_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins: return to IDLE without accepting a key or publishing a result.
        if (i_flush) begin
            state_d = IDLE;
            crc_d   = crc_q;
            cnt_d   = cnt_q;
            key_d   = key_q;
            tag_d   = tag_q;
            hash_d  = hash_q;
            otag_d  = otag_q;
        end

        valid_d = (state_d == DONE);
        ready_d = (state_d == IDLE);
    end

    assign o_key_ready  = ready_q;
    assign o_hash_valid = valid_q;
    assign o_hash       = hash_q;
    assign o_tag        = otag_q;

endmodule

// File: tb/tb_hash_crc_engine.sv
// Scoreboard bench for hash_crc_engine: random traffic, flush/reset aborts, CHUNK_W sweep.
module tb_hash_crc_engine;

    localparam logic [14:0] POLY = 15'h2B9D;
    localparam int          NSW  = 5;

    typedef struct packed {
        logic [14:0] hash;
        logic [3:0]  tag;
    } exp_t;

    function automatic int unsigned cw_of(input int g);
        case (g)
            0:       return 60;
            1:       return 30;
            2:       return 20;
            3:       return 12;
            default: return 1;
        endcase
    endfunction

    // Bit-serial reference: one LFSR step per key bit, MSB first.
    function automatic logic [14:0] ref_crc(input logic [59:0] key, input logic [14:0] seed);
        logic [14:0] c;
        c = seed;
        for (int i = 59; i >= 0; i--) begin
            if (c[14] ^ key[i]) c = {c[13:0], 1'b0} ^ POLY;
            else                c = {c[13:0], 1'b0};
        end
        return c;
    endfunction

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [59:0] key;
    logic [3:0]  tag;
    logic        key_valid;
    logic        key_ready;
    logic [14:0] hash;
    logic [3:0]  otag;
    logic        hash_valid;
    logic        hash_ready;

    logic        sw_flush;
    logic        sw_hready;
    logic [59:0] sw_key;
    logic [3:0]  sw_tag;
    logic        sw_valid;
    logic        sw_kready [NSW];
    logic [14:0] sw_hash   [NSW];
    logic [3:0]  sw_otag   [NSW];
    logic        sw_hvalid [NSW];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic mon_en = 1'b0;
    logic rdy_low = 1'b0;
    logic rdy_high = 1'b0;

    hash_crc_engine dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_key        (key),
        .i_tag        (tag),
        .i_key_valid  (key_valid),
        .o_key_ready  (key_ready),
        .o_hash       (hash),
        .o_tag        (otag),
        .o_hash_valid (hash_valid),
        .i_hash_ready (hash_ready)
    );

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        hash_crc_engine #(
            .CHUNK_W (cw_of(g)),
            .SEED    (15'h0000)
        ) u_sw (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_flush      (sw_flush),
            .i_key        (sw_key),
            .i_tag        (sw_tag),
            .i_key_valid  (sw_valid),
            .o_key_ready  (sw_kready[g]),
            .o_hash       (sw_hash[g]),
            .o_tag        (sw_otag[g]),
            .o_hash_valid (sw_hvalid[g]),
            .i_hash_ready (sw_hready)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Downstream ready: random unless a test pins it.
    initial begin
        hash_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_low)       hash_ready = 1'b0;
            else if (rdy_high) hash_ready = 1'b1;
            else               hash_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare every presented result against the scoreboard head; pop on consume.
    initial begin
        logic        prev_stall;
        logic [14:0] prev_hash;
        logic [3:0]  prev_tag;
        exp_t        e;
        prev_stall = 1'b0;
        prev_hash  = '0;
        prev_tag   = '0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && hash_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got hash %h tag %h, expected none", hash, otag);
                end else begin
                    e = exp_q[0];
                    check("result_hash", 32'(hash), 32'(e.hash));
                    check("result_tag", 32'(otag), 32'(e.tag));
                    if (prev_stall) begin
                        check("stall_hash_stable", 32'(hash), 32'(prev_hash));
                        check("stall_tag_stable", 32'(otag), 32'(prev_tag));
                    end
                    if (hash_ready) void'(exp_q.pop_front());
                end
                prev_stall = !hash_ready;
                prev_hash  = hash;
                prev_tag   = otag;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Offer a key, wait (bounded) for acceptance, optionally push its expected result.
    task automatic send(input logic [59:0] k, input logic [3:0] t, input bit push);
        bit ok;
        ok        = 1'b0;
        key       = k;
        tag       = t;
        key_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (key_ready && !flush) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got key_ready 0 for 200 cycles, expected 1");
        end else if (push) begin
            exp_q.push_back('{hash: ref_crc(k, 15'h7FFF), tag: t});
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge clk);
            c++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [59:0] k;
        logic [3:0]  t;
        int          lat   [NSW];
        logic [14:0] got_h [NSW];
        logic [3:0]  got_t [NSW];
        time         t_acc [2];

        rst_n     = 1'b0;
        flush     = 1'b0;
        key       = '0;
        tag       = '0;
        key_valid = 1'b0;
        sw_flush  = 1'b0;
        sw_hready = 1'b1;
        sw_key    = '0;
        sw_tag    = '0;
        sw_valid  = 1'b0;

        // Reset values while held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_ready", 32'(key_ready), 32'd0);
        check("rst_hash_valid", 32'(hash_valid), 32'd0);
        check("rst_hash", 32'(hash), 32'h7FFF);
        check("rst_tag", 32'(otag), 32'd0);
        check("rst_sw_hash_seed0", 32'(sw_hash[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_key_ready", 32'(key_ready), 32'd1);

        // CHUNK_W sweep with SEED=0: directed keys first, then random.
        for (int n = 0; n < 6; n++) begin
            case (n)
                0:       begin k = 60'h0; t = 4'h5; end
                1:       begin k = 60'h1; t = 4'h3; end
                2:       begin k = 60'h2; t = 4'hA; end
                default: begin k = {28'($urandom), $urandom}; t = 4'($urandom); end
            endcase
            @(negedge clk);
            for (int g = 0; g < NSW; g++) check("sw_key_ready", 32'(sw_kready[g]), 32'd1);
            sw_key   = k;
            sw_tag   = t;
            sw_valid = 1'b1;
            @(posedge clk);
            #1;
            sw_valid = 1'b0;
            for (int g = 0; g < NSW; g++) begin
                lat[g]   = 0;
                got_h[g] = '0;
                got_t[g] = '0;
            end
            for (int c = 1; c <= 70; c++) begin
                @(negedge clk);
                for (int g = 0; g < NSW; g++) begin
                    if (sw_hvalid[g] && lat[g] == 0) begin
                        lat[g]   = c;
                        got_h[g] = sw_hash[g];
                        got_t[g] = sw_otag[g];
                    end
                end
            end
            for (int g = 0; g < NSW; g++) begin
                check("sw_latency", 32'(lat[g]), 32'(60 / cw_of(g)));
                check("sw_hash", 32'(got_h[g]), 32'(ref_crc(k, 15'h0000)));
                check("sw_tag", 32'(got_t[g]), 32'(t));
            end
        end
        if (ref_crc(60'h1, 15'h0) != 15'h2B9D || ref_crc(60'h2, 15'h0) != 15'h573A) begin
            checks++;
            errors++;
            $display("FAIL ref_model_selftest: got %h/%h, expected 2b9d/573a",
                     ref_crc(60'h1, 15'h0), ref_crc(60'h2, 15'h0));
        end

        // Main engine: random traffic with stalls on both sides.
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send({28'($urandom), $urandom}, 4'($urandom), 1'b1);
        end
        drain();

        // Back-to-back throughput: one key every NCHUNK+1 cycles with ready held high.
        rdy_high = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            k = {28'($urandom), $urandom};
            key       = k;
            tag       = 4'(n);
            key_valid = 1'b1;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (key_ready) break;
            end
            t_acc[n] = $time;
            exp_q.push_back('{hash: ref_crc(k, 15'h7FFF), tag: 4'(n)});
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
        check("throughput_cycles", 32'((t_acc[1] - t_acc[0]) / 10), 32'd4);
        drain();
        rdy_high = 1'b0;

        // Flush in CALC: key A vanishes, key B is the only result.
        send(60'hA5A5_5A5A_1234_567, 4'h1, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_calc_ready", 32'(key_ready), 32'd1);
        check("flush_calc_valid", 32'(hash_valid), 32'd0);
        send(60'h0F0F_F0F0_CAFE_BEE, 4'h2, 1'b1);
        drain();

        // Flush in DONE while stalled: valid drops on the next cycle.
        rdy_low = 1'b1;
        @(posedge clk);
        #1;
        send(60'h1357_9BDF_2468_ACE, 4'h7, 1'b1);
        for (int c = 0; c < 20 && !hash_valid; c++) begin
            @(posedge clk);
            #1;
        end
        check("done_valid_before_flush", 32'(hash_valid), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_done_valid", 32'(hash_valid), 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rdy_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("flush_done_no_result", 32'(exp_q.size()), 32'd0);

        // Reset pulse mid-CALC: outputs clear at once, next key hashes correctly.
        send(60'hFEDC_BA98_7654_321, 4'h9, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_hash_valid", 32'(hash_valid), 32'd0);
        check("arst_hash", 32'(hash), 32'h7FFF);
        check("arst_key_ready", 32'(key_ready), 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release_ready", 32'(key_ready), 32'd1);
        send(60'h0123_4567_89AB_CDE, 4'hC, 1'b1);
        send({28'($urandom), $urandom}, 4'hD, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
